// File: rtl/motor_step_driver_if.sv
// Command/status bundle between the motion controller and the two-axis step driver.
// The controller side uses the master modport, the driver uses the slave modport.
interface motor_step_driver_if;
  logic        en;
  logic        theta_pos;
  logic        theta_neg;
  logic        phi_pos;
  logic        phi_neg;
  logic        load;
  logic [15:0] load_theta;
  logic [15:0] load_phi;
  logic        theta_step;
  logic        phi_step;
  logic        theta_dir;
  logic        phi_dir;
  logic [15:0] theta_actual;
  logic [15:0] phi_actual;
  logic        theta_busy;
  logic        phi_busy;
  logic        theta_fault;
  logic        phi_fault;

  modport master (
    output en, theta_pos, theta_neg, phi_pos, phi_neg, load, load_theta, load_phi,
    input  theta_step, phi_step, theta_dir, phi_dir, theta_actual, phi_actual,
    input  theta_busy, phi_busy, theta_fault, phi_fault
  );

  modport slave (
    input  en, theta_pos, theta_neg, phi_pos, phi_neg, load, load_theta, load_phi,
    output theta_step, phi_step, theta_dir, phi_dir, theta_actual, phi_actual,
    output theta_busy, phi_busy, theta_fault, phi_fault
  );
endinterface

// File: rtl/motor_step_driver.sv
// Two-axis step/dir pulse generator with limit-checked 16-bit position tracking.
// Each axis runs an IDLE -> SETUP -> HIGH -> LOW step cycle of CLK_DIV clocks.
module motor_step_axis #(
  parameter int          CLK_DIV  = 10,
  parameter int          PULSE_W  = 3,
  parameter logic [15:0] POS_MIN  = 16'd0,
  parameter logic [15:0] POS_MAX  = 16'd359,
  parameter logic [15:0] POS_INIT = 16'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        cmd_pos,
  input  logic        cmd_neg,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        step,
  output logic        dir,
  output logic [15:0] actual,
  output logic        busy,
  output logic        fault
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] HIGH  = 2'd2;
  localparam logic [1:0] LOW   = 2'd3;
  localparam int LOW_CYC = CLK_DIV - PULSE_W - 2;

  logic [1:0]  state;
  logic [15:0] cnt;
  logic        valid;
  logic [16:0] below_min;
  logic [15:0] clamped;

  // A command in the direction of an already-reached limit is ignored.
  always_comb begin
    valid = en && (cmd_pos != cmd_neg)
            && !(cmd_pos && (actual == POS_MAX))
            && !(cmd_neg && (actual == POS_MIN));
  end

  // 17-bit subtraction detects load values under POS_MIN without an unsigned compare.
  always_comb begin
    below_min = {1'b0, load_val} - {1'b0, POS_MIN};
    clamped   = load_val;
    if (below_min[16])
      clamped = POS_MIN;
    else if (load_val > POS_MAX)
      clamped = POS_MAX;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 16'd0;
      step   <= 1'b0;
      dir    <= 1'b0;
      actual <= POS_INIT;
      fault  <= 1'b0;
    end else begin
      fault <= cmd_pos && cmd_neg;
      if (load) begin
        state  <= IDLE;
        cnt    <= 16'd0;
        step   <= 1'b0;
        actual <= clamped;
      end else begin
        case (state)
          IDLE: begin
            if (valid) begin
              state <= SETUP;
              dir   <= cmd_pos;
            end
          end
          SETUP: begin
            state  <= HIGH;
            step   <= 1'b1;
            cnt    <= 16'(PULSE_W - 1);
            actual <= dir ? (actual + 16'd1) : (actual - 16'd1);
          end
          HIGH: begin
            if (cnt == 16'd0) begin
              state <= LOW;
              step  <= 1'b0;
              cnt   <= 16'(LOW_CYC - 1);
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          LOW: begin
            if (cnt == 16'd0)
              state <= IDLE;
            else
              cnt <= cnt - 16'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

module motor_step_driver #(
  parameter int          CLK_DIV  = 10,
  parameter int          PULSE_W  = 3,
  parameter logic [15:0] POS_MIN  = 16'd0,
  parameter logic [15:0] POS_MAX  = 16'd359,
  parameter logic [15:0] POS_INIT = 16'd0
) (
  input logic              clk,
  input logic              rst,
  motor_step_driver_if.slave bus
);
  motor_step_axis #(
    .CLK_DIV(CLK_DIV), .PULSE_W(PULSE_W),
    .POS_MIN(POS_MIN), .POS_MAX(POS_MAX), .POS_INIT(POS_INIT)
  ) theta_axis (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .cmd_pos  (bus.theta_pos),
    .cmd_neg  (bus.theta_neg),
    .load     (bus.load),
    .load_val (bus.load_theta),
    .step     (bus.theta_step),
    .dir      (bus.theta_dir),
    .actual   (bus.theta_actual),
    .busy     (bus.theta_busy),
    .fault    (bus.theta_fault)
  );

  motor_step_axis #(
    .CLK_DIV(CLK_DIV), .PULSE_W(PULSE_W),
    .POS_MIN(POS_MIN), .POS_MAX(POS_MAX), .POS_INIT(POS_INIT)
  ) phi_axis (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.en),
    .cmd_pos  (bus.phi_pos),
    .cmd_neg  (bus.phi_neg),
    .load     (bus.load),
    .load_val (bus.load_phi),
    .step     (bus.phi_step),
    .dir      (bus.phi_dir),
    .actual   (bus.phi_actual),
    .busy     (bus.phi_busy),
    .fault    (bus.phi_fault)
  );
endmodule

// File: tb/tb_motor_step_driver.sv
// Directed bench for motor_step_driver: stepping cadence, limits, fault, load, reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_motor_step_driver;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  motor_step_driver_if bus ();

  motor_step_driver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic tp, input logic tn, input logic pp, input logic pn);
    bus.theta_pos = tp;
    bus.theta_neg = tn;
    bus.phi_pos   = pp;
    bus.phi_neg   = pn;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  initial begin
    int exp_step;
    int exp_act;

    rst            = 1'b1;
    bus.en         = 1'b1;
    bus.load       = 1'b0;
    bus.load_theta = 16'd0;
    bus.load_phi   = 16'd0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // Reset values on both axes
    checkOutput("rst_theta_step",   16'(bus.theta_step),  16'd0);
    checkOutput("rst_theta_dir",    16'(bus.theta_dir),   16'd0);
    checkOutput("rst_theta_busy",   16'(bus.theta_busy),  16'd0);
    checkOutput("rst_theta_fault",  16'(bus.theta_fault), 16'd0);
    checkOutput("rst_theta_actual", bus.theta_actual,     16'd0);
    checkOutput("rst_phi_step",     16'(bus.phi_step),    16'd0);
    checkOutput("rst_phi_actual",   bus.phi_actual,       16'd0);

    // theta_pos held for three steps: rises at cycles 2, 12, 22, each 3 wide
    $display("[TB] theta_pos cadence");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      if (k == 23) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      exp_step = (k >= 2 && k <= 24 && ((k - 2) % 10) < 3) ? 1 : 0;
      exp_act  = 0;
      if (k >= 2)  exp_act++;
      if (k >= 12) exp_act++;
      if (k >= 22) exp_act++;
      checkOutput("cad_step",   16'(bus.theta_step), 16'(exp_step));
      checkOutput("cad_actual", bus.theta_actual,    16'(exp_act));
      checkOutput("cad_dir",    16'(bus.theta_dir),  16'd1);
    end
    checkOutput("cad_busy_end", 16'(bus.theta_busy), 16'd0);
    checkOutput("cad_phi_idle", bus.phi_actual,      16'd0);

    // phi preset to the upper limit: pos is ignored, neg steps down
    $display("[TB] phi upper limit");
    bus.load_theta = 16'd3;
    bus.load_phi   = 16'd359;
    bus.load       = 1'b1;
    tick();
    bus.load = 1'b0;
    checkOutput("lim_phi_load",   bus.phi_actual,   16'd359);
    checkOutput("lim_theta_keep", bus.theta_actual, 16'd3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkOutput("lim_phi_step", 16'(bus.phi_step), 16'd0);
      checkOutput("lim_phi_busy", 16'(bus.phi_busy), 16'd0);
    end
    checkOutput("lim_phi_actual", bus.phi_actual, 16'd359);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("neg_phi_dir",  16'(bus.phi_dir),  16'd0);
    checkOutput("neg_phi_busy", 16'(bus.phi_busy), 16'd1);
    tick();
    checkOutput("neg_phi_step",   16'(bus.phi_step), 16'd1);
    checkOutput("neg_phi_actual", bus.phi_actual,    16'd358);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) tick();
    checkOutput("neg_phi_done",  16'(bus.phi_busy), 16'd0);
    checkOutput("neg_phi_final", bus.phi_actual,    16'd358);

    // Both theta directions high for 5 cycles
    $display("[TB] theta conflict");
    checkOutput("flt_pre", 16'(bus.theta_fault), 16'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkOutput("flt_high", 16'(bus.theta_fault), 16'd1);
      checkOutput("flt_step", 16'(bus.theta_step),  16'd0);
      checkOutput("flt_busy", 16'(bus.theta_busy),  16'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("flt_clear",  16'(bus.theta_fault), 16'd0);
    checkOutput("flt_actual", bus.theta_actual,     16'd3);

    // One-cycle pos pulse then neg held: +1 step completes, next step returns
    $display("[TB] theta reversal");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) begin
        checkOutput("rev_dir_pos", 16'(bus.theta_dir), 16'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      end
      if (k == 2) begin
        checkOutput("rev_step1",   16'(bus.theta_step), 16'd1);
        checkOutput("rev_actual1", bus.theta_actual,    16'd4);
        checkOutput("rev_dir1",    16'(bus.theta_dir),  16'd1);
      end
      if (k == 11) begin
        checkOutput("rev_dir_neg", 16'(bus.theta_dir),  16'd0);
        checkOutput("rev_busy",    16'(bus.theta_busy), 16'd1);
        checkOutput("rev_hold",    bus.theta_actual,    16'd4);
      end
      if (k == 12) begin
        checkOutput("rev_step2",   16'(bus.theta_step), 16'd1);
        checkOutput("rev_actual2", bus.theta_actual,    16'd3);
      end
    end

    // Load during HIGH, value above the limit gets clamped
    $display("[TB] load during HIGH");
    bus.load_theta = 16'd500;
    bus.load_phi   = 16'd358;
    bus.load       = 1'b1;
    tick();
    bus.load = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ld_step",    16'(bus.theta_step), 16'd0);
    checkOutput("ld_actual",  bus.theta_actual,    16'd359);
    checkOutput("ld_busy",    16'(bus.theta_busy), 16'd0);
    checkOutput("ld_dir",     16'(bus.theta_dir),  16'd0);
    checkOutput("ld_phi",     bus.phi_actual,      16'd358);

    // Reset in the middle of a pulse on both axes, commands held through it
    $display("[TB] reset mid-pulse");
    bus.load_theta = 16'd100;
    bus.load_phi   = 16'd200;
    bus.load       = 1'b1;
    tick();
    bus.load = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("mr_theta_step",   16'(bus.theta_step), 16'd1);
    checkOutput("mr_phi_step",     16'(bus.phi_step),   16'd1);
    checkOutput("mr_theta_actual", bus.theta_actual,    16'd101);
    checkOutput("mr_phi_actual",   bus.phi_actual,      16'd201);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mr_rst_theta_step",   16'(bus.theta_step), 16'd0);
    checkOutput("mr_rst_phi_step",     16'(bus.phi_step),   16'd0);
    checkOutput("mr_rst_phi_dir",      16'(bus.phi_dir),    16'd0);
    checkOutput("mr_rst_phi_busy",     16'(bus.phi_busy),   16'd0);
    checkOutput("mr_rst_theta_busy",   16'(bus.theta_busy), 16'd0);
    checkOutput("mr_rst_theta_actual", bus.theta_actual,    16'd0);
    checkOutput("mr_rst_phi_actual",   bus.phi_actual,      16'd0);
    tick();
    checkOutput("mr_resume_busy", 16'(bus.phi_busy),  16'd1);
    checkOutput("mr_resume_dir",  16'(bus.theta_dir), 16'd1);
    checkOutput("mr_resume_step", 16'(bus.phi_step),  16'd0);
    tick();
    checkOutput("mr_resume_theta_step", 16'(bus.theta_step), 16'd1);
    checkOutput("mr_resume_phi_step",   16'(bus.phi_step),   16'd1);
    checkOutput("mr_resume_theta_act",  bus.theta_actual,    16'd1);
    checkOutput("mr_resume_phi_act",    bus.phi_actual,      16'd1);

    // Dropping en mid-step finishes the step but starts no new one
    $display("[TB] enable gating");
    bus.en = 1'b0;
    tick();
    checkOutput("en_step_continues", 16'(bus.theta_step), 16'd1);
    for (int k = 1; k <= 10; k++) tick();
    checkOutput("en_theta_busy", 16'(bus.theta_busy), 16'd0);
    checkOutput("en_phi_busy",   16'(bus.phi_busy),   16'd0);
    checkOutput("en_theta_act",  bus.theta_actual,    16'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
